// File: rtl/prof_ctr_ctrl_if.sv
// CSR access bus of the profiling counter controller.
// The core side is the master and the counter block is the slave.
interface prof_ctr_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              CsrWrEn;
  logic              CsrRdEn;
  logic [ADDR_W-1:0] CsrAddr;
  logic [31:0]       CsrWData;
  logic [31:0]       CsrRData;
  logic              CsrRdValid;

  modport master (
    output CsrWrEn, CsrRdEn, CsrAddr, CsrWData,
    input  CsrRData, CsrRdValid
  );

  modport slave (
    input  CsrWrEn, CsrRdEn, CsrAddr, CsrWData,
    output CsrRData, CsrRdValid
  );
endinterface

// File: rtl/prof_ctr_ctrl.sv
// Event profiling counters with run/freeze/clear sequencing, a timed window and a CSR port.
// Define PROF_SNAPSHOT_EN to add shadow registers captured by CTRL bit 4.
module prof_ctr_ctrl #(
  parameter int NUM_EVT = 7,
  parameter int CTR_W   = 32,
  parameter int ADDR_W  = 4
) (
  input  logic               Clk,
  input  logic               Rest,
  input  logic [NUM_EVT-1:0] EvtIn,
  prof_ctr_ctrl_if.slave     bus,
  output logic               Busy,
  output logic               IrqOvf
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FREEZE = 2'd2,
    S_CLEAR  = 2'd3
  } state_e;

  localparam int IDX_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_WIN  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_EN   = ADDR_W'(3);

  state_e             state_q;
  logic [IDX_W-1:0]   sweep_q;
  logic [CTR_W-1:0]   cnt_q [NUM_EVT];
  logic [CTR_W-1:0]   cnt_d [NUM_EVT];
  logic [CTR_W-1:0]   ctr_view [NUM_EVT];
  logic [NUM_EVT-1:0] ovf_q, ovf_d;
  logic [NUM_EVT-1:0] evt_en_q;
  logic [NUM_EVT-1:0] inc;
  logic [31:0]        window_q;
  logic [31:0]        win_cnt_q;
  logic               win_mode_q;
  logic               win_done_q;
  logic [31:0]        rdata_q;
  logic               rdvalid_q;
  logic [31:0]        rd_val;

  logic wr_ctrl, wr_win, wr_stat, wr_en;
  logic go_start, go_stop, go_clear, clear_go;
  logic run, win_end;

  always_comb begin
    wr_ctrl  = bus.CsrWrEn && (bus.CsrAddr == A_CTRL);
    wr_win   = bus.CsrWrEn && (bus.CsrAddr == A_WIN);
    wr_stat  = bus.CsrWrEn && (bus.CsrAddr == A_STAT);
    wr_en    = bus.CsrWrEn && (bus.CsrAddr == A_EN);
    go_start = wr_ctrl && bus.CsrWData[0];
    go_stop  = wr_ctrl && bus.CsrWData[1];
    go_clear = wr_ctrl && bus.CsrWData[2];
    clear_go = go_clear && (state_q != S_CLEAR);
    run      = (state_q == S_RUN);
    // The window limit is compared live, so a mid-run Window write takes effect at once.
    win_end  = run && win_mode_q && (window_q != '0) && (win_cnt_q == window_q - 32'd1);
    inc      = run ? (EvtIn & evt_en_q) : '0;
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_stat) ovf_d = ovf_d & ~bus.CsrWData[8 +: NUM_EVT];
    for (int unsigned i = 0; i < NUM_EVT; i++) begin
      cnt_d[i] = cnt_q[i] + CTR_W'(inc[i]);
      if (inc[i] && (cnt_q[i] == '1)) ovf_d[i] = 1'b1;
      if ((state_q == S_CLEAR) && (sweep_q == IDX_W'(i))) cnt_d[i] = '0;
    end
    if (clear_go || (state_q == S_CLEAR)) ovf_d = '0;
  end

`ifdef PROF_SNAPSHOT_EN
  logic             go_snap;
  logic [CTR_W-1:0] shadow_q [NUM_EVT];

  assign go_snap = wr_ctrl && bus.CsrWData[4];

  // Shadows take cnt_d so the snapshot includes events counted in the snapshot cycle.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      for (int unsigned i = 0; i < NUM_EVT; i++) shadow_q[i] <= '0;
    end else if (clear_go || (state_q == S_CLEAR)) begin
      for (int unsigned i = 0; i < NUM_EVT; i++) shadow_q[i] <= '0;
    end else if (go_snap) begin
      for (int unsigned i = 0; i < NUM_EVT; i++) shadow_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_EVT; i++) ctr_view[i] = shadow_q[i];
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < NUM_EVT; i++) ctr_view[i] = cnt_q[i];
  end
`endif

  always_comb begin
    rd_val = '0;
    case (bus.CsrAddr)
      A_CTRL:  rd_val = {28'b0, win_mode_q, 3'b0};
      A_WIN:   rd_val = window_q;
      A_STAT:  rd_val = {16'b0, 8'(ovf_q), 5'b0, win_done_q, 2'(state_q)};
      A_EN:    rd_val = 32'(evt_en_q);
      default: begin
        for (int unsigned i = 0; i < NUM_EVT; i++) begin
          if (bus.CsrAddr == ADDR_W'(8 + i)) rd_val = 32'(ctr_view[i]);
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state_q    <= S_IDLE;
      sweep_q    <= '0;
      for (int unsigned i = 0; i < NUM_EVT; i++) cnt_q[i] <= '0;
      ovf_q      <= '0;
      evt_en_q   <= '1;
      window_q   <= '0;
      win_cnt_q  <= '0;
      win_mode_q <= 1'b0;
      win_done_q <= 1'b0;
      rdata_q    <= '0;
      rdvalid_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_EVT; i++) cnt_q[i] <= cnt_d[i];
      ovf_q     <= ovf_d;
      rdvalid_q <= bus.CsrRdEn;
      rdata_q   <= bus.CsrRdEn ? rd_val : '0;
      if (wr_ctrl) win_mode_q <= bus.CsrWData[3];
      if (wr_win)  window_q   <= bus.CsrWData;
      if (wr_en)   evt_en_q   <= bus.CsrWData[NUM_EVT-1:0];
      // W1C first; a window end in the same cycle re-sets WinDone below.
      if (wr_stat && bus.CsrWData[2]) win_done_q <= 1'b0;

      case (state_q)
        S_IDLE, S_FREEZE: begin
          if (go_clear) begin
            state_q    <= S_CLEAR;
            sweep_q    <= '0;
            win_cnt_q  <= '0;
            win_done_q <= 1'b0;
          end else if (go_start && !go_stop) begin
            state_q    <= S_RUN;
            win_cnt_q  <= '0;
            win_done_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (go_clear) begin
            state_q    <= S_CLEAR;
            sweep_q    <= '0;
            win_cnt_q  <= '0;
            win_done_q <= 1'b0;
          end else begin
            if (win_mode_q) win_cnt_q <= win_cnt_q + 32'd1;
            if (win_end) begin
              state_q    <= S_FREEZE;
              win_done_q <= 1'b1;
            end else if (go_stop) begin
              state_q <= S_FREEZE;
            end
          end
        end
        S_CLEAR: begin
          win_cnt_q  <= '0;
          win_done_q <= 1'b0;
          if (sweep_q == IDX_W'(NUM_EVT - 1)) state_q <= S_IDLE;
          else                                sweep_q <= sweep_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.CsrRData   = rdata_q;
  assign bus.CsrRdValid = rdvalid_q;
  assign Busy           = (state_q == S_CLEAR);
  assign IrqOvf         = |(ovf_q & evt_en_q);

endmodule

// File: tb/tb_prof_ctr_ctrl.sv
// Self-checking bench for prof_ctr_ctrl: register table, hand-written sequences and a
// randomized run checked against a per-event counting model. Counters are 8 bits wide so wrap is reachable.
`timescale 1ns/1ps
module tb_prof_ctr_ctrl;
  localparam int NUM_EVT = 7;
  localparam int CTR_W   = 8;
  localparam int ADDR_W  = 4;
`ifdef PROF_SNAPSHOT_EN
  localparam logic [31:0] T6_EXP = 32'd4;
`else
  localparam logic [31:0] T6_EXP = 32'd7;
`endif

  logic               Clk = 1'b0;
  logic               Rest = 1'b0;
  logic [NUM_EVT-1:0] EvtIn = '0;
  logic               Busy;
  logic               IrqOvf;

  prof_ctr_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  prof_ctr_ctrl #(.NUM_EVT(NUM_EVT), .CTR_W(CTR_W), .ADDR_W(ADDR_W)) dut (
    .Clk    (Clk),
    .Rest   (Rest),
    .EvtIn  (EvtIn),
    .bus    (bus),
    .Busy   (Busy),
    .IrqOvf (IrqOvf)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  int          mcnt [NUM_EVT];
  logic [6:0]  movf;
  logic [6:0]  men;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
    bus.CsrWrEn = 1'b1; bus.CsrAddr = a; bus.CsrWData = d;
    tick();
    bus.CsrWrEn = 1'b0;
  endtask

  task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
    bus.CsrRdEn = 1'b1; bus.CsrAddr = a;
    tick();
    bus.CsrRdEn = 1'b0;
    check("rd_valid", 32'(bus.CsrRdValid), 32'd1);
    d = bus.CsrRData;
  endtask

  task automatic read_check(input logic [3:0] a, input logic [31:0] exp, input string name);
    logic [31:0] v;
    csr_read(a, v);
    check(name, v, exp);
  endtask

  task automatic pulse(input logic [NUM_EVT-1:0] ev, input int n);
    EvtIn = ev;
    repeat (n) tick();
    EvtIn = '0;
  endtask

  task automatic do_clear();
    int n;
    csr_write(4'd0, 32'h4);
    n = 0;
    while (Busy && n < 50) begin n++; tick(); end
    check("clear_busy_cycles", 32'(n), 32'd7);
  endtask

  task automatic model_events(input logic [6:0] ev);
    for (int i = 0; i < NUM_EVT; i++) begin
      if (ev[i] && men[i]) begin
        mcnt[i] = (mcnt[i] + 1) % 256;
        if (mcnt[i] == 0) movf[i] = 1'b1;
      end
    end
  endtask

  task automatic check_model_counters(input string tag);
    for (int i = 0; i < NUM_EVT; i++)
      read_check(4'(8 + i), 32'(mcnt[i]), $sformatf("%s_cnt%0d", tag, i));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    logic [31:0] v;
    int n;
    int w;
    logic [6:0] ev;

    bus.CsrWrEn = 1'b0; bus.CsrRdEn = 1'b0; bus.CsrAddr = '0; bus.CsrWData = '0;
    repeat (3) tick();
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_irq", 32'(IrqOvf), 32'd0);
    check("reset_rdvalid", 32'(bus.CsrRdValid), 32'd0);
    check("reset_rdata", bus.CsrRData, 32'd0);
    Rest = 1'b1;
    tick();

    // Register map table: reads after reset, R/W masking, unmapped accesses.
    vt.push_back('{1'b0, 4'd2,  32'd0,         32'd0});
    vt.push_back('{1'b0, 4'd3,  32'd0,         32'h7F});
    vt.push_back('{1'b0, 4'd0,  32'd0,         32'd0});
    vt.push_back('{1'b0, 4'd1,  32'd0,         32'd0});
    vt.push_back('{1'b0, 4'd8,  32'd0,         32'd0});
    vt.push_back('{1'b0, 4'd14, 32'd0,         32'd0});
    vt.push_back('{1'b0, 4'd15, 32'd0,         32'd0});
    vt.push_back('{1'b0, 4'd5,  32'd0,         32'd0});
    vt.push_back('{1'b1, 4'd1,  32'h12345678,  32'd0});
    vt.push_back('{1'b0, 4'd1,  32'd0,         32'h12345678});
    vt.push_back('{1'b1, 4'd3,  32'hFFFFFF05,  32'd0});
    vt.push_back('{1'b0, 4'd3,  32'd0,         32'h05});
    vt.push_back('{1'b1, 4'd0,  32'h8,         32'd0});
    vt.push_back('{1'b0, 4'd0,  32'd0,         32'h8});
    vt.push_back('{1'b0, 4'd2,  32'd0,         32'd0});
    vt.push_back('{1'b1, 4'd0,  32'h0,         32'd0});
    vt.push_back('{1'b0, 4'd0,  32'd0,         32'd0});
    vt.push_back('{1'b1, 4'd5,  32'hFFFF,      32'd0});
    vt.push_back('{1'b1, 4'd15, 32'hFF,        32'd0});
    vt.push_back('{1'b0, 4'd1,  32'd0,         32'h12345678});
    vt.push_back('{1'b0, 4'd3,  32'd0,         32'h05});
    vt.push_back('{1'b1, 4'd2,  32'hFFFFFFFF,  32'd0});
    vt.push_back('{1'b0, 4'd2,  32'd0,         32'd0});
    vt.push_back('{1'b1, 4'd3,  32'h7F,        32'd0});
    vt.push_back('{1'b1, 4'd1,  32'd0,         32'd0});
    vt.push_back('{1'b0, 4'd3,  32'd0,         32'h7F});
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].wr) csr_write(vt[i].addr, vt[i].data);
      else          read_check(vt[i].addr, vt[i].exp, $sformatf("table%0d_addr%0d", i, vt[i].addr));
    end

    // Same-cycle read and write of one address returns the old value.
    bus.CsrRdEn = 1'b1; bus.CsrWrEn = 1'b1; bus.CsrAddr = 4'd1; bus.CsrWData = 32'hA5A5;
    tick();
    bus.CsrRdEn = 1'b0; bus.CsrWrEn = 1'b0;
    check("rw_same_cycle_old", bus.CsrRData, 32'd0);
    read_check(4'd1, 32'hA5A5, "rw_same_cycle_new");
    tick();
    check("rdvalid_one_cycle", 32'(bus.CsrRdValid), 32'd0);
    csr_write(4'd1, 32'd0);

    // T2: counting in RUN, dropped in FREEZE; stop beats start.
    csr_write(4'd0, 32'h1);
    pulse(7'h04, 10);
    csr_write(4'd0, 32'h2);
    read_check(4'd10, 32'd10, "t2_cnt2_run");
    pulse(7'h04, 5);
    read_check(4'd10, 32'd10, "t2_cnt2_freeze");
    read_check(4'd2, 32'h2, "t2_state_freeze");
    csr_write(4'd0, 32'h3);
    read_check(4'd2, 32'h2, "prio_stop_over_start");

    // T3: timed window of 5 cycles, then a 1-cycle window.
    csr_write(4'd0, 32'h8);
    csr_write(4'd1, 32'd5);
    EvtIn = 7'h01;
    csr_write(4'd0, 32'h9);
    repeat (10) tick();
    EvtIn = '0;
    read_check(4'd8, 32'd5, "t3_cnt0");
    read_check(4'd2, 32'h6, "t3_status");
    csr_write(4'd2, 32'h4);
    read_check(4'd2, 32'h2, "t3_w1c_windone");
    read_check(4'd0, 32'h8, "t3_winmode_rb");
    csr_write(4'd1, 32'd1);
    EvtIn = 7'h01;
    csr_write(4'd0, 32'h9);
    repeat (3) tick();
    EvtIn = '0;
    read_check(4'd8, 32'd6, "win1_cnt0");
    read_check(4'd2, 32'h6, "win1_status");
    csr_write(4'd2, 32'h4);

    // T4: wrap, sticky flag, IRQ masking by EVT_EN, W1C.
    csr_write(4'd0, 32'h1);
    pulse(7'h08, 255);
    read_check(4'd11, 32'hFF, "t4_cnt3_max");
    read_check(4'd2, 32'h1, "t4_no_ovf_yet");
    pulse(7'h08, 1);
    read_check(4'd11, 32'h0, "t4_cnt3_wrap");
    read_check(4'd2, 32'h801, "t4_ovf_flag");
    check("t4_irq_set", 32'(IrqOvf), 32'd1);
    csr_write(4'd3, 32'h77);
    check("t4_irq_masked", 32'(IrqOvf), 32'd0);
    read_check(4'd2, 32'h801, "t4_flag_sticky");
    csr_write(4'd3, 32'h7F);
    check("t4_irq_unmasked", 32'(IrqOvf), 32'd1);
    csr_write(4'd2, 32'h800);
    read_check(4'd2, 32'h1, "t4_w1c_ovf");
    check("t4_irq_cleared", 32'(IrqOvf), 32'd0);

    // T5: clear from RUN; start during the sweep is ignored.
    pulse(7'h7F, 3);
    csr_write(4'd0, 32'h4);
    EvtIn = 7'h7F;
    bus.CsrWrEn = 1'b1; bus.CsrAddr = 4'd0; bus.CsrWData = 32'h1;
    n = 0;
    while (Busy && n < 50) begin
      n++;
      tick();
      bus.CsrWrEn = 1'b0;
    end
    EvtIn = '0;
    check("t5_busy_cycles", 32'(n), 32'd7);
    read_check(4'd2, 32'h0, "t5_idle");
    for (int i = 0; i < NUM_EVT; i++) read_check(4'(8 + i), 32'd0, $sformatf("t5_cnt%0d", i));
    csr_write(4'd0, 32'h3);
    read_check(4'd2, 32'h0, "prio_idle_stop_start");

    // T6: snapshot isolates the counter view from later events.
    csr_write(4'd0, 32'h1);
    pulse(7'h02, 4);
    csr_write(4'd0, 32'h10);
    pulse(7'h02, 3);
    csr_write(4'd0, 32'h2);
    read_check(4'd9, T6_EXP, "t6_cnt1_view");
    csr_write(4'd0, 32'h10);
    read_check(4'd9, 32'd7, "t6_cnt1_resnap");

    // Randomized free run against the counting model.
    do_clear();
    read_check(4'd2, 32'h0, "rand_idle");
    for (int i = 0; i < NUM_EVT; i++) mcnt[i] = 0;
    movf = '0;
    men = 7'($urandom_range(1, 127));
    csr_write(4'd3, 32'(men));
    csr_write(4'd0, 32'h1);
    for (int c = 0; c < 600; c++) begin
      ev = 7'($urandom_range(0, 127));
      EvtIn = ev;
      model_events(ev);
      tick();
    end
    EvtIn = '0;
    csr_write(4'd0, 32'h2);
    csr_write(4'd0, 32'h10);
    check_model_counters("rand");
    read_check(4'd2, 32'h2 | (32'(movf) << 8), "rand_status");
    check("rand_irq", 32'(IrqOvf), 32'(|(movf & men)));

    // Randomized windows: only the first W RUN cycles count.
    for (int k = 0; k < 4; k++) begin
      w = $urandom_range(1, 12);
      men = 7'($urandom_range(0, 127));
      csr_write(4'd3, 32'(men));
      csr_write(4'd1, 32'(w));
      csr_write(4'd0, 32'h9);
      for (int j = 0; j < w + 4; j++) begin
        ev = 7'($urandom_range(0, 127));
        EvtIn = ev;
        if (j < w) model_events(ev);
        tick();
      end
      EvtIn = '0;
      read_check(4'd2, 32'h6 | (32'(movf) << 8), $sformatf("win%0d_status", k));
      csr_write(4'd0, 32'h18);
      check_model_counters($sformatf("win%0d", k));
    end
    csr_write(4'd0, 32'h0);

    // Reset in the middle of a sweep.
    csr_write(4'd3, 32'h7F);
    csr_write(4'd0, 32'h1);
    pulse(7'h7F, 3);
    csr_write(4'd0, 32'h4);
    tick(); tick();
    check("sweep_busy_before_reset", 32'(Busy), 32'd1);
    Rest = 1'b0;
    #1;
    check("sweep_reset_busy", 32'(Busy), 32'd0);
    check("sweep_reset_irq", 32'(IrqOvf), 32'd0);
    tick();
    Rest = 1'b1;
    read_check(4'd2, 32'h0, "sweep_reset_status");
    read_check(4'd3, 32'h7F, "sweep_reset_en");
    read_check(4'd14, 32'h0, "sweep_reset_cnt6");

    // Reset in the middle of a window.
    csr_write(4'd1, 32'd100);
    csr_write(4'd0, 32'h9);
    pulse(7'h7F, 4);
    Rest = 1'b0;
    tick();
    Rest = 1'b1;
    read_check(4'd2, 32'h0, "win_reset_status");
    read_check(4'd0, 32'h0, "win_reset_ctrl");
    read_check(4'd1, 32'h0, "win_reset_window");
    read_check(4'd8, 32'h0, "win_reset_cnt0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
